hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Parametrised pipeline-control block for the in-order RV32 core; replaces the inline stall and zap logic around IF/ID and ID/EX.
- Tracks in-flight destination registers in a scoreboard shift register.
- Generates load-use and RAW stalls, optional forwarding selects, and multi-cycle branch flush.
- Sits beside the ID stage. Its outputs drive the IF/ID enable, ID/EX bubble insertion and EX operand muxes.

Parameters:
- REG_IDX_W, 5, register index width.
- TRACK_DEPTH, 2, number of post-ID stages tracked (entry 0 = EX, entry k = k stages past EX); 1..4.
- FORWARD_EN, 1, 1 = forward where possible; 0 = stall on any tracked RAW match.
- LOAD_LAT, 1, load data is forwardable only from entry index >= LOAD_LAT; 0..TRACK_DEPTH-1.
- FLUSH_CYCLES, 2, cycles the IF/ID squash stays asserted after a taken branch; 1..4.
- FWD_W, $clog2(TRACK_DEPTH+1), forward-select width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1_idx  in  REG_IDX_W  source 1 index
- id_rs2_idx  in  REG_IDX_W  source 2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd_idx  in  REG_IDX_W  destination index
- id_reg_wr  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- ex_take_branch  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; freezes whole pipeline
- if_id_enable  out  1  IF/ID and PC update enable
- id_ex_bubble  out  1  load a NOP/invalid into ID/EX
- if_id_flush  out  1  load NOP into IF/ID
- fwd_a_sel  out  FWD_W  rs1 source for the ID instruction (0 = regfile, k = entry k-1 result)
- fwd_b_sel  out  FWD_W  rs2 source, same encoding
- stall_cycles  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, rst=1):
  - All scoreboard entries invalid; flush counter 0; stall_cycles 0.
  - Outputs: if_id_enable=1, id_ex_bubble=0, if_id_flush=0, fwd_*_sel=0.
- Scoreboard entry fields: valid, rd, is_load. Entry is "live" when valid && rd!=0.
- Match on source s against entry k: s_used && live(k) && rd(k)==s_idx. The lowest k (youngest) wins.
- Hazard for a source:
  - FORWARD_EN=0: any match.
  - FORWARD_EN=1: match at k where is_load(k) && k < LOAD_LAT.
- stall = id_valid && hazard(rs1 or rs2) && !flush_active.
- fwd_sel:
  - If FORWARD_EN=1 and matched with no hazard: k+1.
  - Otherwise 0. Forced 0 when FORWARD_EN=0.
  - Combinational, same cycle as the ID instruction.
- flush_active = ex_take_branch || flush_cnt != 0.
- Priority, freeze > flush > stall:
  - mem_busy=1: if_id_enable=0, id_ex_bubble=0, if_id_flush=0. Scoreboard, counter and stall_cycles hold. ex_take_branch is ignored.
  - ex_take_branch=1 (not frozen): if_id_flush=1, id_ex_bubble=1, if_id_enable=1 (PC takes target). flush_cnt <= FLUSH_CYCLES-1.
  - flush_cnt!=0 (not frozen): if_id_flush=1, id_ex_bubble=1, flush_cnt decrements. A new taken branch reloads the counter.
  - stall: if_id_enable=0, id_ex_bubble=1, stall_cycles += 1, saturating at 0xFFFF_FFFF.
  - Otherwise: if_id_enable=1, bubble=0, flush=0.
- Scoreboard shift (when not frozen):
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {id_valid && id_reg_wr && !bubble, id_rd_idx, id_is_load}. Invalid when id_ex_bubble.
- Writes to x0 are never tracked. The register file is write-through, so the WB slot is not tracked.
- Latency: hazard outputs are combinational. State updates on the next clk rising edge.

Decomposition:
- Shared package gets:
  - a scoreboard entry typedef {valid, rd, is_load}
  - FWD_SEL_RF = 0
  - parameter legality checks: static asserts on TRACK_DEPTH, LOAD_LAT, FLUSH_CYCLES ranges
- One sub-module, hazard_src_match: compares one source against all entries and returns hazard and fwd_sel. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Defaults. ADD x5 in EX, then ID issues SUB rs1=x5 → no stall, fwd_a_sel=1. Next cycle, with the producer in entry 1 → fwd_a_sel=2.
- LW x7 in EX, then ID issues ADD rs2=x7 → if_id_enable=0 and id_ex_bubble=1 for exactly 1 cycle, stall_cycles=1. Next cycle fwd_b_sel=2, no stall.
- FORWARD_EN=0, TRACK_DEPTH=3. ADD x3 followed by a dependent instruction → 3 stall cycles, fwd_sel=0 throughout. A dependency on x0 → no stall.
- ex_take_branch pulse for 1 cycle with FLUSH_CYCLES=2 → if_id_flush=1 and id_ex_bubble=1 for 2 consecutive cycles. A concurrent RAW hazard raises no stall and no stall_cycles increment.
- mem_busy held 3 cycles during a load-use stall → outputs frozen, scoreboard and stall_cycles unchanged. The stall resumes for 1 cycle after release.
- rst asserted mid-flush (flush_cnt=1) → immediately flush=0, if_id_enable=1, scoreboard empty. The next dependent instruction does not stall.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/flush controller.
// Also provides the parameter legality check used by the top at elaboration.
package hazard_flush_ctrl_pkg;

  localparam int SB_RD_W     = 8;
  localparam int FLUSH_CNT_W = 2;
  localparam int FWD_SEL_RF  = 0;

  // rd is stored zero-extended to SB_RD_W so the type is independent of REG_IDX_W.
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  function automatic bit params_legal(int track_depth, int load_lat,
                                      int flush_cycles, int reg_idx_w);
    return (track_depth >= 1) && (track_depth <= 4) &&
           (load_lat >= 0) && (load_lat < track_depth) &&
           (flush_cycles >= 1) && (flush_cycles <= 4) &&
           (reg_idx_w >= 1) && (reg_idx_w <= SB_RD_W);
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_src_match.sv
// Matches one ID source register against every scoreboard entry and returns
// the hazard flag plus the forward select of the youngest matching producer.
module hazard_src_match
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int REG_IDX_W   = 5,
  parameter int TRACK_DEPTH = 2,
  parameter int FORWARD_EN  = 1,
  parameter int LOAD_LAT    = 1,
  parameter int FWD_W       = $clog2(TRACK_DEPTH + 1)
) (
  input  logic [REG_IDX_W-1:0] src_idx,
  input  logic                 src_used,
  input  sb_entry_t            entries [TRACK_DEPTH],
  output logic                 hazard,
  output logic [FWD_W-1:0]     fwd_sel
);

  always_comb begin
    hazard  = 1'b0;
    fwd_sel = FWD_W'(FWD_SEL_RF);
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
      if (src_used && entries[k].valid && (entries[k].rd != '0) &&
          (entries[k].rd == SB_RD_W'(src_idx))) begin
        if ((FORWARD_EN == 0) || (entries[k].is_load && (k < LOAD_LAT))) begin
          hazard  = 1'b1;
          fwd_sel = FWD_W'(FWD_SEL_RF);
        end else begin
          hazard  = 1'b0;
          fwd_sel = FWD_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline control beside ID: scoreboard of in-flight destinations, load-use/RAW
// stall, operand forward selects and multi-cycle IF/ID squash after taken branches.
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int REG_IDX_W    = 5,
  parameter int TRACK_DEPTH  = 2,
  parameter int FORWARD_EN   = 1,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int FWD_W        = $clog2(TRACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1_idx,
  input  logic [REG_IDX_W-1:0] id_rs2_idx,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] id_rd_idx,
  input  logic                 id_reg_wr,
  input  logic                 id_is_load,
  input  logic                 ex_take_branch,
  input  logic                 mem_busy,
  output logic                 if_id_enable,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic [FWD_W-1:0]     fwd_a_sel,
  output logic [FWD_W-1:0]     fwd_b_sel,
  output logic [31:0]          stall_cycles
);

  if (!params_legal(TRACK_DEPTH, LOAD_LAT, FLUSH_CYCLES, REG_IDX_W)) begin : g_param_check
    $error("hazard_flush_ctrl: illegal parameter combination");
  end

  sb_entry_t              sb [TRACK_DEPTH];
  sb_entry_t              new_entry;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   haz_a;
  logic                   haz_b;
  logic                   flush_active;
  logic                   stall;

  hazard_src_match #(
    .REG_IDX_W  (REG_IDX_W),
    .TRACK_DEPTH(TRACK_DEPTH),
    .FORWARD_EN (FORWARD_EN),
    .LOAD_LAT   (LOAD_LAT),
    .FWD_W      (FWD_W)
  ) u_match_a (
    .src_idx (id_rs1_idx),
    .src_used(id_rs1_used),
    .entries (sb),
    .hazard  (haz_a),
    .fwd_sel (fwd_a_sel)
  );

  hazard_src_match #(
    .REG_IDX_W  (REG_IDX_W),
    .TRACK_DEPTH(TRACK_DEPTH),
    .FORWARD_EN (FORWARD_EN),
    .LOAD_LAT   (LOAD_LAT),
    .FWD_W      (FWD_W)
  ) u_match_b (
    .src_idx (id_rs2_idx),
    .src_used(id_rs2_used),
    .entries (sb),
    .hazard  (haz_b),
    .fwd_sel (fwd_b_sel)
  );

  assign flush_active = ex_take_branch || (flush_cnt != '0);
  assign stall        = id_valid && (haz_a || haz_b) && !flush_active;

  // Freeze beats flush beats stall.
  always_comb begin
    if_id_enable = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (mem_busy) begin
      if_id_enable = 1'b0;
    end else if (flush_active) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    new_entry.valid   = id_valid && id_reg_wr && !id_ex_bubble && (id_rd_idx != '0);
    new_entry.rd      = SB_RD_W'(id_rd_idx);
    new_entry.is_load = id_is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TRACK_DEPTH; k++) sb[k] <= '0;
      flush_cnt    <= '0;
      stall_cycles <= '0;
    end else if (!mem_busy) begin
      for (int k = 1; k < TRACK_DEPTH; k++) sb[k] <= sb[k-1];
      sb[0] <= new_entry;
      if (ex_take_branch) flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
      if (stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Vector-table bench for hazard_flush_ctrl: a default instance and a
// no-forwarding, depth-3 instance share inputs; expectations go through a queue.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 0, id_rs1_used = 0, id_rs2_used = 0;
  logic [4:0] id_rs1_idx = 0, id_rs2_idx = 0, id_rd_idx = 0;
  logic       id_reg_wr = 0, id_is_load = 0, ex_take_branch = 0, mem_busy = 0;

  logic        en_d, bub_d, fl_d, en_n, bub_n, fl_n;
  logic [1:0]  fa_d, fb_d, fa_n, fb_n;
  logic [31:0] sc_d, sc_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
    .if_id_enable(en_d), .id_ex_bubble(bub_d), .if_id_flush(fl_d),
    .fwd_a_sel(fa_d), .fwd_b_sel(fb_d), .stall_cycles(sc_d)
  );

  hazard_flush_ctrl #(.TRACK_DEPTH(3), .FORWARD_EN(0), .LOAD_LAT(1)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .ex_take_branch(ex_take_branch), .mem_busy(mem_busy),
    .if_id_enable(en_n), .id_ex_bubble(bub_n), .if_id_flush(fl_n),
    .fwd_a_sel(fa_n), .fwd_b_sel(fb_n), .stall_cycles(sc_n)
  );

  typedef struct {
    bit          nf;
    logic        valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr, ld, br, busy;
    logic        en, bub, fl;
    logic [1:0]  fa, fb;
    logic [31:0] sc;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string tag, bit nf, logic valid, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic [4:0] rd, logic wr, logic ld,
                              logic br, logic busy, logic en, logic bub, logic fl,
                              logic [1:0] fa, logic [1:0] fb, logic [31:0] sc);
    vec_t t;
    t.tag = tag; t.nf = nf; t.valid = valid; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.wr = wr; t.ld = ld; t.br = br; t.busy = busy;
    t.en = en; t.bub = bub; t.fl = fl; t.fa = fa; t.fb = fb; t.sc = sc;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid = t.valid; id_rs1_idx = t.rs1; id_rs1_used = t.u1;
    id_rs2_idx = t.rs2; id_rs2_used = t.u2; id_rd_idx = t.rd;
    id_reg_wr = t.wr; id_is_load = t.ld; ex_take_branch = t.br; mem_busy = t.busy;
  endtask

  task automatic compare(vec_t e);
    if (e.nf) begin
      chk({e.tag, ".en"}, 32'(en_n), 32'(e.en));
      chk({e.tag, ".bub"}, 32'(bub_n), 32'(e.bub));
      chk({e.tag, ".fl"}, 32'(fl_n), 32'(e.fl));
      chk({e.tag, ".fa"}, 32'(fa_n), 32'(e.fa));
      chk({e.tag, ".fb"}, 32'(fb_n), 32'(e.fb));
      chk({e.tag, ".sc"}, sc_n, e.sc);
    end else begin
      chk({e.tag, ".en"}, 32'(en_d), 32'(e.en));
      chk({e.tag, ".bub"}, 32'(bub_d), 32'(e.bub));
      chk({e.tag, ".fl"}, 32'(fl_d), 32'(e.fl));
      chk({e.tag, ".fa"}, 32'(fa_d), 32'(e.fa));
      chk({e.tag, ".fb"}, 32'(fb_d), 32'(e.fb));
      chk({e.tag, ".sc"}, sc_d, e.sc);
    end
  endtask

  task automatic apply(vec_t t);
    @(posedge clk); #1;
    drive(t);
    exp_q.push_back(t);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s.queue: got empty expected 1 entry", t.tag);
    end else begin
      compare(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    vec_t idle;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //          tag   nf v  rs1 u1 rs2 u2 rd wr ld br by  en b fl fa fb sc
    vecs.push_back(mk("A0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("A1", 0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("A2", 0, 1, 5, 1, 6, 1, 8, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("A3", 0, 1, 5, 1, 8, 1, 0, 1, 0, 0, 0,  1, 0, 0, 2, 1, 0));
    vecs.push_back(mk("A4", 0, 1, 8, 1, 0, 1, 7, 1, 1, 0, 0,  1, 0, 0, 2, 0, 0));
    vecs.push_back(mk("A5", 0, 1, 1, 1, 7, 1, 9, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("A6", 0, 1, 1, 1, 7, 1, 9, 1, 0, 0, 0,  1, 0, 0, 0, 2, 1));
    vecs.push_back(mk("A7", 0, 1, 9, 0, 9, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("A8", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 0, 1));
    vecs.push_back(mk("B0", 0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("B1", 0, 1, 4, 1, 0, 0,10, 1, 0, 1, 0,  1, 1, 1, 0, 0, 1));
    vecs.push_back(mk("B2", 0, 1, 4, 1, 0, 0,10, 1, 0, 0, 0,  1, 1, 1, 2, 0, 1));
    vecs.push_back(mk("B3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("C0", 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,  1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("C1", 0, 1, 0, 0, 7, 1,11, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("C2", 0, 1, 0, 0, 7, 1,11, 1, 0, 1, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("C3", 0, 1, 0, 0, 7, 1,11, 1, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("C4", 0, 1, 0, 0, 7, 1,11, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("C5", 0, 1, 0, 0, 7, 1,11, 1, 0, 0, 0,  1, 0, 0, 0, 2, 2));
    vecs.push_back(mk("D0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 2));
    vecs.push_back(mk("D1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 2));
    vecs.push_back(mk("D2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 2));
    vecs.push_back(mk("D3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 2));
    // No-forwarding instance: a producer blocks its consumer for all three tracked stages.
    vecs.push_back(mk("N0", 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("N1", 1, 1, 3, 1, 0, 0,12, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("N2", 1, 1, 3, 1, 0, 0,12, 1, 0, 0, 0,  0, 1, 0, 0, 0, 1));
    vecs.push_back(mk("N3", 1, 1, 3, 1, 0, 0,12, 1, 0, 0, 0,  0, 1, 0, 0, 0, 2));
    vecs.push_back(mk("N4", 1, 1, 3, 1, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 3));
    vecs.push_back(mk("N5", 1, 1, 0, 1, 0, 1,13, 1, 0, 0, 0,  1, 0, 0, 0, 0, 3));
    vecs.push_back(mk("N6", 1, 1,13, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 3));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].tag == "N0") do_reset();
      apply(vecs[i]);
    end

    // Asynchronous reset while the squash counter is still running.
    do_reset();
    apply(mk("R0", 0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    apply(mk("R1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0));
    apply(mk("R2", 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 2, 0, 0));
    #1 rst = 1'b1;
    #1;
    chk("R2rst.fl", 32'(fl_d), 32'd0);
    chk("R2rst.en", 32'(en_d), 32'd1);
    chk("R2rst.bub", 32'(bub_d), 32'd0);
    chk("R2rst.fa", 32'(fa_d), 32'd0);
    #1 rst = 1'b0;
    apply(mk("R3", 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
